rf_writeback_scheduler: RTL and testbench
=========================================

# rf_writeback_scheduler

Write-port scheduler and scoreboard for the CPU register file. It arbitrates the register file's single write port between the ALU writeback and load-return writeback using round-robin. It tracks one busy bit per architectural register and stalls instruction issue on RAW/WAW hazards until the pending write has reached the register file. It sits between the issue/decode stage, the two writeback sources, and the register file's write port (iWriteEnable/iWriteAddress/iDataIn).

## Interface
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers (register 0 hardwired zero)

- Clock  in  1  system clock, rising edge
- Reset_n  in  1  reset; asynchronous, active-low
- iIssueValid  in  1  decode presents an instruction this cycle
- iIssueRs0, iIssueRs1  in  ADDR_WIDTH  source register addresses
- iIssueRd  in  ADDR_WIDTH  destination register address
- iIssueRdValid  in  1  instruction writes iIssueRd
- oIssueStall  out  1  hold instruction in decode (combinational)
- iAluValid  in  1  ALU writeback request; held until granted
- iAluAddr / iAluData  in  ADDR_WIDTH / DATA_WIDTH  ALU writeback target/value
- oAluGrant  out  1  ALU request accepted this cycle (combinational)
- iLoadValid  in  1  load writeback request; held until granted
- iLoadAddr / iLoadData  in  ADDR_WIDTH / DATA_WIDTH  load target/value
- oLoadGrant  out  1  load request accepted this cycle (combinational)
- oWriteEnable  out  1  to register file iWriteEnable (registered)
- oWriteAddress  out  ADDR_WIDTH  to register file iWriteAddress (registered)
- oWriteData  out  DATA_WIDTH  to register file iDataIn (registered)
- oBusyMask  out  NUM_REGS  scoreboard, bit i = write to register i pending
- oPendingCount  out  ADDR_WIDTH+1  population count of oBusyMask (registered)
- oProtocolError  out  1  sticky: write granted to a non-busy nonzero register

## Operation
- Issue: oIssueStall = iIssueValid & (busy[Rs0] | busy[Rs1] | (iIssueRdValid & busy[Rd])). busy[0] always 0.
- Scoreboard set: on a rising edge with iIssueValid & ~oIssueStall & iIssueRdValid & Rd≠0, set busy[Rd].
- Scoreboard clear: on a rising edge with oWriteEnable & oWriteAddress≠0, clear busy[oWriteAddress].
- Set and clear of the same register on the same edge is impossible (set requires ~busy, clear requires busy). If it occurs anyway, set wins.
- Arbitration is round-robin with a 1-bit priority pointer, reset value = ALU.
  - Only one requester valid: it is granted.
  - Both valid: the pointer side is granted, and the pointer flips to the other side.
  - Single-requester grants also move the pointer to the other side.
  - Exactly one grant per cycle maximum.
- Granted request is registered into oWriteEnable/oWriteAddress/oWriteData on the next edge. With no grant, oWriteEnable = 0 and the address/data outputs hold.
- A granted write to address 0 is forwarded, but the scoreboard is untouched.
- A granted write to a nonzero non-busy register sets oProtocolError (sticky until reset). The write is still forwarded.
- oPendingCount tracks oBusyMask popcount, max NUM_REGS.

## Timing
- Reset (async assert, sync-safe deassert): oWriteEnable=0, oWriteAddress=0, oWriteData=0, oBusyMask=0, oPendingCount=0, oProtocolError=0, pointer=ALU. In-flight grants are discarded.
- Grant in cycle N. oWriteEnable high in cycle N+1. Register file stores at the end of N+1, and busy clears at the same edge.
- Dependent instruction is unstalled in cycle N+2. Its registered read at the end of N+2 returns the new value, so no forwarding is required.
- Issue in cycle N with Rd: busy visible (stall dependents) from cycle N+1.
- Requester whose valid drops before grant: no write, no state change.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate ALU, Load, ALU, …

## Test plan
- Reset, then ALU write r5=0x1234 with no issue -> oAluGrant in cycle 0. oWriteEnable/addr 5/data 0x1234 in cycle 1. oProtocolError=1.
- Issue Rd=r3, next cycle issue Rs0=r3 -> stall asserted. ALU write r3 granted at N -> stall deasserts at N+2, oBusyMask[3] 1→0, oPendingCount 1→0.
- ALU and Load both valid for 4 cycles after reset -> grant sequence ALU, Load, ALU, Load. Each loser holds and is granted next cycle.
- Issue Rd=r0 -> oBusyMask unchanged. Write to r0 granted -> oWriteEnable=1, no error flag.
- WAW: r7 busy, issue Rd=r7 -> stall until r7 write reaches oWriteEnable+1 cycle.
- Assert Reset_n low mid-stream with r1, r2 busy and a grant pending -> all outputs zero immediately (asynchronously). After release: no stale write, and stalls are cleared.

Source files
------------

// File: rtl/rf_writeback_scheduler.sv
// Purpose: round-robin arbiter for the single register-file write port (ALU vs load) plus a busy-bit scoreboard that stalls issue on hazards.
// Latency: grant is combinational in cycle N, the write is presented to the register file in N+1, and busy clears at the end of N+1.
// Backpressure: a losing requester holds its valid until granted; issue is held combinationally by oIssueStall while any operand or destination is busy.
module rf_writeback_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  iIssueValid,
   input  logic [ADDR_WIDTH-1:0] iIssueRs0,
   input  logic [ADDR_WIDTH-1:0] iIssueRs1,
   input  logic [ADDR_WIDTH-1:0] iIssueRd,
   input  logic                  iIssueRdValid,
   output logic                  oIssueStall,
   input  logic                  iAluValid,
   input  logic [ADDR_WIDTH-1:0] iAluAddr,
   input  logic [DATA_WIDTH-1:0] iAluData,
   output logic                  oAluGrant,
   input  logic                  iLoadValid,
   input  logic [ADDR_WIDTH-1:0] iLoadAddr,
   input  logic [DATA_WIDTH-1:0] iLoadData,
   output logic                  oLoadGrant,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [DATA_WIDTH-1:0] oWriteData,
   output logic [NUM_REGS-1:0]   oBusyMask,
   output logic [ADDR_WIDTH:0]   oPendingCount,
   output logic                  oProtocolError
);

   // Scoreboard and its registered population count; bit 0 is never set.
   logic [NUM_REGS-1:0]   busy_q;
   logic [NUM_REGS-1:0]   busy_nxt;
   logic [ADDR_WIDTH:0]   pend_q;
   logic [ADDR_WIDTH:0]   pend_nxt;

   // Round-robin pointer: 0 means the ALU wins a tie, 1 means the load wins.
   logic                  prio_load_q;

   // Registered write port.
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;

   logic                  grant_alu;
   logic                  grant_load;
   logic                  grant_any;
   logic [ADDR_WIDTH-1:0] gaddr;
   logic [DATA_WIDTH-1:0] gdata;
   logic                  wb_clear;
   logic                  gaddr_busy;
   logic                  err_set;
   logic                  issue_set;

   // Hazard detection: stall when any source, or the destination (WAW), still awaits its write.
   always_comb begin
      oIssueStall = iIssueValid & (busy_q[iIssueRs0] | busy_q[iIssueRs1] |
                                   (iIssueRdValid & busy_q[iIssueRd]));
      issue_set   = iIssueValid & ~oIssueStall & iIssueRdValid & (iIssueRd != '0);
   end

   // Arbitration: a lone requester always wins; on a tie the pointer side wins.
   always_comb begin
      grant_alu  = iAluValid & (~iLoadValid | ~prio_load_q);
      grant_load = iLoadValid & ~grant_alu;
      grant_any  = grant_alu | grant_load;
      gaddr      = grant_alu ? iAluAddr : iLoadAddr;
      gdata      = grant_alu ? iAluData : iLoadData;
   end

   // Error detection: a granted write must target a register that is still busy after
   // this edge's clear; the write currently on the port is retiring its own busy bit.
   always_comb begin
      wb_clear   = we_q & (waddr_q != '0);
      gaddr_busy = busy_q[gaddr] & ~(wb_clear & (waddr_q == gaddr));
      err_set    = grant_any & (gaddr != '0) & ~gaddr_busy;
   end

   // Next scoreboard: clear the retiring write, then apply the issue set so set wins a collision.
   always_comb begin
      busy_nxt = busy_q;
      if (wb_clear) begin
         busy_nxt[waddr_q] = 1'b0;
      end
      if (issue_set) begin
         busy_nxt[iIssueRd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
      pend_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pend_nxt = pend_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
      end
   end

   // Scoreboard state and pending count.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         busy_q <= busy_nxt;
         pend_q <= pend_nxt;
      end
   end

   // Pointer moves to the side that was not granted, whether or not there was a tie.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         prio_load_q <= 1'b0;
      end else if (grant_alu) begin
         prio_load_q <= 1'b1;
      end else if (grant_load) begin
         prio_load_q <= 1'b0;
      end
   end

   // Write port register: address and data hold when nothing is granted.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= grant_any;
         if (grant_any) begin
            waddr_q <= gaddr;
            wdata_q <= gdata;
         end
      end
   end

   // Sticky protocol error flag.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign oAluGrant      = grant_alu;
   assign oLoadGrant     = grant_load;
   assign oWriteEnable   = we_q;
   assign oWriteAddress  = waddr_q;
   assign oWriteData     = wdata_q;
   assign oBusyMask      = busy_q;
   assign oPendingCount  = pend_q;
   assign oProtocolError = err_q;

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Bench for rf_writeback_scheduler: directed vectors, a behavioural model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_rf_writeback_scheduler;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b0;
   logic          iIssueValid, iIssueRdValid;
   logic [AW-1:0] iIssueRs0, iIssueRs1, iIssueRd;
   logic          iAluValid, iLoadValid;
   logic [AW-1:0] iAluAddr, iLoadAddr;
   logic [DW-1:0] iAluData, iLoadData;
   logic          oIssueStall, oAluGrant, oLoadGrant, oWriteEnable, oProtocolError;
   logic [AW-1:0] oWriteAddress;
   logic [DW-1:0] oWriteData;
   logic [NR-1:0] oBusyMask;
   logic [AW:0]   oPendingCount;

   rf_writeback_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .iIssueValid(iIssueValid), .iIssueRs0(iIssueRs0), .iIssueRs1(iIssueRs1),
      .iIssueRd(iIssueRd), .iIssueRdValid(iIssueRdValid), .oIssueStall(oIssueStall),
      .iAluValid(iAluValid), .iAluAddr(iAluAddr), .iAluData(iAluData), .oAluGrant(oAluGrant),
      .iLoadValid(iLoadValid), .iLoadAddr(iLoadAddr), .iLoadData(iLoadData), .oLoadGrant(oLoadGrant),
      .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData),
      .oBusyMask(oBusyMask), .oPendingCount(oPendingCount), .oProtocolError(oProtocolError)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: which registers await a write, whose turn a tie goes to,
   // what the register file sees this cycle, and the sticky error.
   bit            mb [NR];
   bit            m_alu_turn;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit            m_err;
   bit            last_alu_grant;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [NR-1:0] model_mask();
      logic [NR-1:0] m;
      for (int i = 0; i < NR; i++) m[i] = mb[i];
      return m;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < NR; i++) c += int'(mb[i]);
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mb[i] = 1'b0;
      m_alu_turn = 1'b1;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
   endtask

   task automatic idle();
      iIssueValid = 0; iIssueRdValid = 0; iIssueRs0 = 0; iIssueRs1 = 0; iIssueRd = 0;
      iAluValid = 0; iAluAddr = 0; iAluData = 0;
      iLoadValid = 0; iLoadAddr = 0; iLoadData = 0;
   endtask

   task automatic issue(input int rs0, input int rs1, input int rd, input bit rdv);
      iIssueValid = 1; iIssueRs0 = AW'(rs0); iIssueRs1 = AW'(rs1);
      iIssueRd = AW'(rd); iIssueRdValid = rdv;
   endtask

   task automatic alu_req(input int a, input logic [DW-1:0] d);
      iAluValid = 1; iAluAddr = AW'(a); iAluData = d;
   endtask

   task automatic load_req(input int a, input logic [DW-1:0] d);
      iLoadValid = 1; iLoadAddr = AW'(a); iLoadData = d;
   endtask

   // One clock cycle: compare every output against the model mid-cycle, then advance the model.
   task automatic tick();
      bit            stall, ga, gl;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(negedge Clock);
      stall = iIssueValid && (mb[iIssueRs0] || mb[iIssueRs1] || (iIssueRdValid && mb[iIssueRd]));
      if (iAluValid && iLoadValid) ga = m_alu_turn;
      else ga = iAluValid;
      gl = iLoadValid && !ga;
      chk("stall", oIssueStall, stall);
      chk("alu_grant", oAluGrant, ga);
      chk("load_grant", oLoadGrant, gl);
      chk("write_enable", oWriteEnable, m_we);
      chk("write_addr", oWriteAddress, m_addr);
      chk("write_data", oWriteData, m_data);
      chk("busy_mask", oBusyMask, model_mask());
      chk("pending_count", oPendingCount, model_count());
      chk("protocol_error", oProtocolError, m_err);
      last_alu_grant = ga;
      a = ga ? iAluAddr : iLoadAddr;
      d = ga ? iAluData : iLoadData;
      if (ga || gl) begin
         // legal only if the target is waiting and is not the register retiring right now
         if (a != 0 && !(mb[a] && !(m_we && m_addr == a))) m_err = 1'b1;
         m_alu_turn = gl;
      end
      if (m_we && m_addr != 0) mb[m_addr] = 1'b0;
      if (iIssueValid && !stall && iIssueRdValid && iIssueRd != 0) mb[iIssueRd] = 1'b1;
      m_we = ga || gl;
      if (ga || gl) begin
         m_addr = a;
         m_data = d;
      end
      @(posedge Clock);
      #1;
   endtask

   // Asynchronous reset mid-cycle, checked before any clock edge, released away from the edge.
   task automatic do_reset();
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_we", oWriteEnable, 0);
      chk("rst_addr", oWriteAddress, 0);
      chk("rst_data", oWriteData, 0);
      chk("rst_busy", oBusyMask, 0);
      chk("rst_pending", oPendingCount, 0);
      chk("rst_err", oProtocolError, 0);
      idle();
      model_reset();
      @(posedge Clock);
      @(posedge Clock);
      #3 Reset_n = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] ad, ld;
      idle();
      model_reset();
      do_reset();

      // Unsolicited ALU write to r5 is granted, forwarded and flagged.
      alu_req(5, 32'h1234);
      #1;
      chk("t1_alu_grant", oAluGrant, 1);
      chk("t1_load_grant", oLoadGrant, 0);
      tick();
      idle();
      #1;
      chk("t1_we", oWriteEnable, 1);
      chk("t1_addr", oWriteAddress, 5);
      chk("t1_data", oWriteData, 32'h1234);
      chk("t1_err", oProtocolError, 1);
      tick();
      tick();
      chk("t1_err_sticky", oProtocolError, 1);
      chk("t1_addr_hold", oWriteAddress, 5);

      // RAW on r3: stall from issue+1 until two cycles after the grant.
      do_reset();
      issue(0, 0, 3, 1);
      #1 chk("t2_no_stall", oIssueStall, 0);
      tick();
      idle(); issue(3, 0, 0, 0); alu_req(3, 32'hAAAA_0003);
      #1;
      chk("t2_stall_n", oIssueStall, 1);
      chk("t2_busy_n", oBusyMask[3], 1);
      chk("t2_pend_n", oPendingCount, 1);
      tick();
      iAluValid = 0;
      #1;
      chk("t2_stall_n1", oIssueStall, 1);
      chk("t2_we_n1", oWriteEnable, 1);
      tick();
      #1;
      chk("t2_stall_n2", oIssueStall, 0);
      chk("t2_busy_n2", oBusyMask[3], 0);
      chk("t2_pend_n2", oPendingCount, 0);
      tick();
      idle();
      tick();
      chk("t2_err", oProtocolError, 0);

      // Both requesters valid after reset: ALU, Load, ALU, Load; losers hold their data.
      do_reset();
      ad = 32'hA000_0000;
      ld = 32'hB000_0000;
      for (int c = 0; c < 4; c++) begin
         alu_req(0, ad);
         load_req(0, ld);
         #1;
         chk("t3_alu_grant", oAluGrant, (c % 2 == 0));
         chk("t3_load_grant", oLoadGrant, (c % 2 == 1));
         if (c == 2) chk("t3_held_load_data", oWriteData, 32'hB000_0000);
         tick();
         if (last_alu_grant) ad = ad + 1;
         else ld = ld + 1;
      end
      idle();
      tick();

      // Rd = r0 never becomes busy; a write to r0 is forwarded without error.
      issue(0, 0, 0, 1);
      tick();
      idle();
      chk("t4_busy", oBusyMask, 0);
      chk("t4_pend", oPendingCount, 0);
      load_req(0, 32'h5555);
      tick();
      idle();
      chk("t4_we", oWriteEnable, 1);
      chk("t4_addr", oWriteAddress, 0);
      chk("t4_data", oWriteData, 32'h5555);
      chk("t4_err", oProtocolError, 0);
      tick();

      // WAW on r7: second writer of r7 waits for the first write to land.
      issue(0, 0, 7, 1);
      tick();
      issue(0, 0, 7, 1); load_req(7, 32'h7777);
      #1 chk("t5_stall_n", oIssueStall, 1);
      tick();
      iLoadValid = 0;
      #1;
      chk("t5_stall_n1", oIssueStall, 1);
      chk("t5_addr_n1", oWriteAddress, 7);
      tick();
      #1 chk("t5_stall_n2", oIssueStall, 0);
      tick();
      idle();
      #1 chk("t5_rebusy", oBusyMask[7], 1);
      alu_req(7, 32'h0707);
      tick();
      idle();
      tick();
      tick();
      chk("t5_busy_clear", oBusyMask, 0);
      chk("t5_err", oProtocolError, 0);

      // Reset mid-stream with r1/r2 busy, a write on the port and a grant pending.
      issue(0, 0, 1, 1);
      tick();
      issue(0, 0, 2, 1);
      tick();
      idle(); alu_req(1, 32'h1111);
      tick();
      idle(); load_req(2, 32'h2222);
      #1;
      chk("t6_load_grant", oLoadGrant, 1);
      chk("t6_busy_pre", oBusyMask, 32'h0000_0006);
      chk("t6_we_pre", oWriteEnable, 1);
      do_reset();
      issue(1, 2, 0, 0);
      #1 chk("t6_no_stall", oIssueStall, 0);
      tick();
      idle();
      chk("t6_no_stale_write", oWriteEnable, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
